// File: rtl/conv_relu_pool_engine.sv
// Zero-padded KxK conv + bias + ReLU into layer0, then 2x2 max-pool with round-up into layer1 when LAYER1_POOL_EN is defined.
// Fixed cost: K*K+2 cycles per conv pixel, 6 cycles per pool word; no backpressure, memories must serve one access per cycle.
module conv_relu_pool_engine #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int K     = 5,
    parameter int DW    = 13,
    parameter int FRAC  = 4,
    parameter int ACC_W = 32,
    localparam int AW   = $clog2(IMG_W*IMG_H),
    localparam int CW   = $clog2(K*K+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    input  logic          coef_we,
    input  logic [CW-1:0] coef_addr,
    input  logic [DW-1:0] coef_data,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          csel
);
    localparam int NT  = K*K;
    localparam int P   = (K-1)/2;
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int KW  = $clog2(K);
    localparam int PXW = XW-1;
    localparam int PYW = $clog2(IMG_H/2);
    localparam int AW1 = ACC_W+1;
    localparam int IW  = DW-FRAC;
    localparam logic signed [ACC_W:0] SMAX = AW1'((1 << (DW-1)) - 1);
    localparam logic [DW-1:0] TOPC = {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CONV_TAP, S_CONV_DRAIN, S_CONV_WR,
        S_POOL_RD, S_POOL_CMP, S_POOL_WR, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;
    logic                    r_busy;
    logic [YW-1:0]           r_row;
    logic [XW-1:0]           r_col;
    logic [KW-1:0]           r_dy, r_dx;
    logic [CW-1:0]           r_tap, r_pidx;
    logic [PYW-1:0]          r_pi;
    logic [PXW-1:0]          r_pj;
    logic [1:0]              r_pk;
    logic                    r_pvld, r_pinb, r_rvld, r_rfirst;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DW-1:0]    r_max;
    logic signed [DW-1:0]    r_coef [NT];
    logic signed [DW-1:0]    r_bias;
    logic [AW-1:0]           r_iaddr, r_raddr, r_waddr;
    logic [DW-1:0]           r_wdat;

    logic [15:0]             w_ty, w_tx;
    logic                    w_inb, w_last_tap, w_last_pix, w_last_pool;
    logic [AW-1:0]           w_tap_addr, w_conv_waddr, w_pool_raddr, w_pool_waddr;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W:0]   w_sum;
    logic [DW-1:0]           w_conv_res, w_pool_res;

    // Out-of-range taps wrap to huge unsigned values, so one compare covers both edges.
    assign w_ty         = 16'(r_row) + 16'(r_dy) - 16'(P);
    assign w_tx         = 16'(r_col) + 16'(r_dx) - 16'(P);
    assign w_inb        = (w_ty < 16'(IMG_H)) && (w_tx < 16'(IMG_W));
    assign w_tap_addr   = AW'(32'(w_ty) * 32'(IMG_W) + 32'(w_tx));
    assign w_conv_waddr = AW'(32'(r_row) * 32'(IMG_W) + 32'(r_col));
    assign w_pool_raddr = AW'(32'({r_pi, r_pk[1]}) * 32'(IMG_W) + 32'({r_pj, r_pk[0]}));
    assign w_pool_waddr = AW'(32'(r_pi) * 32'(IMG_W/2) + 32'(r_pj));
    assign w_last_tap   = (r_tap == CW'(NT-1));
    assign w_last_pix   = (r_row == YW'(IMG_H-1)) && (r_col == XW'(IMG_W-1));
    assign w_last_pool  = (r_pi == PYW'(IMG_H/2-1)) && (r_pj == PXW'(IMG_W/2-1));

    assign w_prod  = $signed(idata) * r_coef[r_pidx];
    assign w_shift = r_acc >>> FRAC;
    assign w_sum   = AW1'(w_shift) + AW1'(r_bias);
    assign busy    = r_busy;

    always_comb begin
        if (w_sum[ACC_W])       w_conv_res = '0;
        else if (w_sum > SMAX)  w_conv_res = SMAX[DW-1:0];
        else                    w_conv_res = w_sum[DW-1:0];
    end

    always_comb begin
        w_pool_res = r_max;
        if (r_max[FRAC-1:0] != '0) begin
            if ({r_max[DW-1:FRAC], {FRAC{1'b0}}} == TOPC) w_pool_res = TOPC;
            else w_pool_res = {r_max[DW-1:FRAC] + IW'(1), {FRAC{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Address/data outputs hold their last driven value outside their own states.
    always_comb begin
        w_state_nxt = r_state;
        cwr         = 1'b0;
        crd         = 1'b0;
        csel        = 1'b0;
        iaddr       = r_iaddr;
        caddr_rd    = r_raddr;
        caddr_wr    = r_waddr;
        cdata_wr    = r_wdat;
        case (r_state)
            S_IDLE:       if (ready) w_state_nxt = S_CONV_TAP;
            S_CONV_TAP: begin
                if (w_inb) iaddr = w_tap_addr;
                if (w_last_tap) w_state_nxt = S_CONV_DRAIN;
            end
            S_CONV_DRAIN: w_state_nxt = S_CONV_WR;
            S_CONV_WR: begin
                cwr      = 1'b1;
                caddr_wr = w_conv_waddr;
                cdata_wr = w_conv_res;
`ifdef LAYER1_POOL_EN
                w_state_nxt = w_last_pix ? S_POOL_RD : S_CONV_TAP;
`else
                w_state_nxt = w_last_pix ? S_DONE : S_CONV_TAP;
`endif
            end
            S_POOL_RD: begin
                crd      = 1'b1;
                caddr_rd = w_pool_raddr;
                if (r_pk == 2'd3) w_state_nxt = S_POOL_CMP;
            end
            S_POOL_CMP:   w_state_nxt = S_POOL_WR;
            S_POOL_WR: begin
                cwr         = 1'b1;
                csel        = 1'b1;
                caddr_wr    = w_pool_waddr;
                cdata_wr    = w_pool_res;
                w_state_nxt = w_last_pool ? S_DONE : S_POOL_RD;
            end
            S_DONE:       w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_iaddr <= '0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_wdat  <= '0;
        end else begin
            if (r_state == S_IDLE && ready) r_busy <= 1'b1;
            else if (w_state_nxt == S_DONE) r_busy <= 1'b0;
            r_iaddr <= iaddr;
            r_raddr <= caddr_rd;
            r_waddr <= caddr_wr;
            r_wdat  <= cdata_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) r_coef[i] <= '0;
            r_bias <= '0;
        end else if (coef_we && !r_busy) begin
            if (coef_addr < CW'(NT))       r_coef[coef_addr] <= $signed(coef_data);
            else if (coef_addr == CW'(NT)) r_bias <= $signed(coef_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= '0; r_col <= '0; r_dy <= '0; r_dx <= '0;
            r_tap <= '0; r_pi <= '0; r_pj <= '0; r_pk <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row <= '0; r_col <= '0; r_dy <= '0; r_dx <= '0;
                    r_tap <= '0; r_pi <= '0; r_pj <= '0; r_pk <= '0;
                end
                S_CONV_TAP: begin
                    if (w_last_tap) begin
                        r_tap <= '0; r_dx <= '0; r_dy <= '0;
                    end else begin
                        r_tap <= r_tap + CW'(1);
                        if (r_dx == KW'(K-1)) begin
                            r_dx <= '0;
                            r_dy <= r_dy + KW'(1);
                        end else begin
                            r_dx <= r_dx + KW'(1);
                        end
                    end
                end
                S_CONV_WR: begin
                    if (r_col == XW'(IMG_W-1)) begin
                        r_col <= '0;
                        r_row <= r_row + YW'(1);
                    end else begin
                        r_col <= r_col + XW'(1);
                    end
                end
                S_POOL_RD: r_pk <= r_pk + 2'd1;
                S_POOL_WR: begin
                    if (r_pj == PXW'(IMG_W/2-1)) begin
                        r_pj <= '0;
                        r_pi <= r_pi + PYW'(1);
                    end else begin
                        r_pj <= r_pj + PXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lags its address by one cycle, so tap and pool flags are delayed to match.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pvld <= 1'b0; r_pinb <= 1'b0; r_pidx <= '0; r_acc <= '0;
            r_rvld <= 1'b0; r_rfirst <= 1'b0; r_max <= '0;
        end else begin
            r_pvld   <= (r_state == S_CONV_TAP);
            r_pinb   <= w_inb;
            r_pidx   <= r_tap;
            r_rvld   <= (r_state == S_POOL_RD);
            r_rfirst <= (r_state == S_POOL_RD) && (r_pk == 2'd0);
            if (r_state == S_CONV_WR || r_state == S_IDLE) r_acc <= '0;
            else if (r_pvld && r_pinb)                     r_acc <= r_acc + ACC_W'(w_prod);
            if (r_rvld && (r_rfirst || $signed(cdata_rd) > r_max)) r_max <= $signed(cdata_rd);
        end
    end
endmodule

// File: tb/tb_conv_relu_pool_engine.sv
// Directed bench for conv_relu_pool_engine on an 8x8 image with K=5, with image ROM and layer memory models.
module tb_conv_relu_pool_engine;
    localparam int W = 8, H = 8, K = 5, DW = 13, NT = 25, AW = 6, CW = 5;
`ifdef LAYER1_POOL_EN
    localparam int EXP_BUSY = W*H*(K*K+2) + (W*H/4)*6;
    localparam int EXP_WR1  = W*H/4;
    localparam int EXP_RD   = W*H;
`else
    localparam int EXP_BUSY = W*H*(K*K+2);
    localparam int EXP_WR1  = 0;
    localparam int EXP_RD   = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, ready, coef_we;
    logic [CW-1:0] coef_addr;
    logic [DW-1:0] coef_data, idata, cdata_rd, cdata_wr;
    logic [AW-1:0] iaddr, caddr_rd, caddr_wr;
    logic          busy, crd, cwr, csel;

    logic [DW-1:0] rom [64];
    logic [DW-1:0] l0  [64];
    logic [DW-1:0] l1  [16];
    int n_chk = 0, n_bad = 0;
    int m_wr0, m_wr1, m_rd, m_both;

    conv_relu_pool_engine #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW), .FRAC(4), .ACC_W(32)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .iaddr(iaddr), .idata(idata),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        idata <= rom[iaddr];
        if (crd) cdata_rd <= l0[caddr_rd];
        if (cwr) begin
            if (csel) l1[caddr_wr[3:0]] <= cdata_wr;
            else      l0[caddr_wr]      <= cdata_wr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cwr && !csel) m_wr0++;
        if (cwr && csel)  m_wr1++;
        if (crd)          m_rd++;
        if (cwr && crd)   m_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic prog(input logic [DW-1:0] cen, input logic [DW-1:0] oth, input logic [DW-1:0] bias);
        for (int a = 0; a <= NT; a++) begin
            coef_we   = 1'b1;
            coef_addr = CW'(a);
            coef_data = (a == NT) ? bias : ((a == NT/2) ? cen : oth);
            @(negedge clk);
        end
        coef_we = 1'b0;
    endtask

    task automatic clr_mon();
        m_wr0 = 0; m_wr1 = 0; m_rd = 0; m_both = 0;
    endtask

    // Full run; poke=1 pulses ready and a coefficient write while busy, both of which must be ignored.
    task automatic run(input string tag, input bit poke);
        int n;
        for (int i = 0; i < 64; i++) l0[i] = 13'h1ABC;
        for (int i = 0; i < 16; i++) l1[i] = 13'h1ABC;
        clr_mon();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            n++;
            if (poke && n == 3) begin
                coef_we = 1'b1; coef_addr = 5'd12; coef_data = '0; ready = 1'b1;
            end else begin
                coef_we = 1'b0; ready = 1'b0;
            end
            @(negedge clk);
        end
        coef_we = 1'b0; ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_busy_len"}, 32'(n), 32'(EXP_BUSY));
        chk({tag, "_l0_writes"}, 32'(m_wr0), 32'(W*H));
        chk({tag, "_l1_writes"}, 32'(m_wr1), 32'(EXP_WR1));
        chk({tag, "_reads"}, 32'(m_rd), 32'(EXP_RD));
        chk({tag, "_rd_wr_overlap"}, 32'(m_both), 32'd0);
    endtask

    initial begin
        logic signed [DW-1:0] p;
        int k;
        reset = 1'b1; ready = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cwr", 32'(cwr), 0);
        chk("rst_crd", 32'(crd), 0);
        chk("rst_csel", 32'(csel), 0);
        chk("rst_iaddr", 32'(iaddr), 0);
        chk("rst_caddr_rd", 32'(caddr_rd), 0);
        chk("rst_caddr_wr", 32'(caddr_wr), 0);
        chk("rst_cdata_wr", 32'(cdata_wr), 0);
        reset = 1'b0;
        @(negedge clk);

        // A: zero coefficients, bias -0.75 -> everything clamps to 0
        prog(13'h0000, 13'h0000, 13'h1FF4);
        for (int i = 0; i < 64; i++) rom[i] = 13'($urandom);
        run("A", 1'b0);
        for (int i = 0; i < 64; i++) chk($sformatf("A_l0_%0d", i), 32'(l0[i]), 0);
`ifdef LAYER1_POOL_EN
        for (int i = 0; i < 16; i++) chk($sformatf("A_l1_%0d", i), 32'(l1[i]), 0);
`endif

        // B: identity kernel -> layer0 is ReLU(pixel)
        prog(13'h0010, 13'h0000, 13'h0000);
        for (int i = 0; i < 64; i++) rom[i] = 13'(i*8 - 256);
        rom[40] = 13'h1FF0;
        run("B", 1'b1);
        for (int i = 0; i < 64; i++) begin
            p = $signed(rom[i]);
            chk($sformatf("B_l0_%0d", i), 32'(l0[i]), (p < 0) ? 32'd0 : 32'(rom[i]));
        end
        chk("B_neg_one", 32'(l0[40]), 0);
        chk("B_last", 32'(l0[63]), 32'h00F8);

        // C: box filter of ones -> count of in-bounds taps
        prog(13'h0010, 13'h0010, 13'h0000);
        for (int i = 0; i < 64; i++) rom[i] = 13'h0010;
        run("C", 1'b0);
        chk("C_corner0", 32'(l0[0]), 32'h0090);
        chk("C_edge1", 32'(l0[1]), 32'h00C0);
        chk("C_inner_1_1", 32'(l0[9]), 32'h0100);
        chk("C_inner_2_2", 32'(l0[2*W+2]), 32'h0190);
        chk("C_corner63", 32'(l0[63]), 32'h0090);
`ifdef LAYER1_POOL_EN
        chk("C_l1_0", 32'(l1[0]), 32'h0100);
`endif

        // D: coefficients retained; large image saturates
        for (int i = 0; i < 64; i++) rom[i] = 13'h0FFF;
        run("D", 1'b0);
        for (int i = 0; i < 64; i++) chk($sformatf("D_l0_%0d", i), 32'(l0[i]), 32'h0FFF);
`ifdef LAYER1_POOL_EN
        for (int i = 0; i < 16; i++) chk($sformatf("D_l1_%0d", i), 32'(l1[i]), 32'h0FF0);
`endif

        // R: reset in the middle of a run
        clr_mon();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        k = 0;
`ifdef LAYER1_POOL_EN
        while (crd !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
`else
        while (k < 500) begin @(negedge clk); k++; end
`endif
        chk("R_midrun_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("R_busy", 32'(busy), 0);
        chk("R_cwr", 32'(cwr), 0);
        chk("R_crd", 32'(crd), 0);
        reset = 1'b0;
        clr_mon();
        repeat (20) @(negedge clk);
        chk("R_no_writes", 32'(m_wr0 + m_wr1), 0);

        // E: fresh run after reset, pool round-up blocks
        prog(13'h0010, 13'h0000, 13'h0000);
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = 13'h0011; rom[1]  = 13'h0012; rom[8]  = 13'h0010; rom[9]  = 13'h0000;
        rom[2] = 13'h0030;
        rom[4] = 13'h1FF0; rom[5]  = 13'h1FE0; rom[12] = 13'h1FFF; rom[13] = 13'h1FF8;
        rom[6] = 13'h0021;
        run("E", 1'b0);
        chk("E_l0_0", 32'(l0[0]), 32'h0011);
        chk("E_l0_2", 32'(l0[2]), 32'h0030);
        chk("E_l0_4", 32'(l0[4]), 0);
        chk("E_l0_6", 32'(l0[6]), 32'h0021);
`ifdef LAYER1_POOL_EN
        chk("E_l1_0", 32'(l1[0]), 32'h0020);
        chk("E_l1_1", 32'(l1[1]), 32'h0030);
        chk("E_l1_2", 32'(l1[2]), 0);
        chk("E_l1_3", 32'(l1[3]), 32'h0030);
        for (int i = 4; i < 16; i++) chk($sformatf("E_l1_%0d", i), 32'(l1[i]), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
